execute_stage_mc: RTL and testbench

- Parametrised next-generation execute stage of the pipelined core.
- Resolves forwarding, runs the ALU, computes the branch target and decides PCSrc from a registered flag set.
- New relative to the current stage: a multi-cycle multiply with a stall output, an explicit flag-set control, an EX flush, and a memory-side hold of the EX/MEM register.
- Sits between the ID/EX register and the memory stage; drives the EX/MEM register.

---
 rtl/exec_pkg.sv | 62 ++++++
 rtl/exec_mul_unit.sv | 81 ++++++++
 rtl/execute_stage_mc.sv | 196 +++++++++++++++++++
 tb/tb_execute_stage_mc.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types, default widths and the branch-condition helper for the
// multi-cycle execute stage.
package exec_pkg;

  localparam int DATA_W_DEF  = 19;
  localparam int PC_W_DEF    = 15;
  localparam int REG_AW_DEF  = 5;
  localparam int MUL_LAT_DEF = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SHL = 3'b101,
    ALU_SHR = 3'b110,
    ALU_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_GE   = 2'b01,
    BR_LT   = 2'b10,
    BR_EQ   = 2'b11
  } branch_e;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10,
    FWD_RSVD = 2'b11
  } fwd_sel_e;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_MUL  = 1'b1
  } mul_state_e;

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_write;
    logic result_src;
    logic cant_byte;
  } exmem_t;

  // Signed compares use N^V so GE/LT stay correct across overflow.
  function automatic logic branch_cond(input logic [1:0] br, input logic z,
                                       input logic n, input logic v, input logic jump);
    logic c;
    case (branch_e'(br))
      BR_EQ:   c = z;
      BR_GE:   c = ~(n ^ v);
      BR_LT:   c = n ^ v;
      BR_NONE: c = 1'b0;
      default: c = 1'b0;
    endcase
    return c | jump;
  endfunction

endpackage

// File: rtl/exec_mul_unit.sv
// Multi-cycle multiplier: captures operands on issue, counts down the latency
// and presents the low product bits on the completing cycle.
module exec_mul_unit
  import exec_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              hold_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] product_o
);

  localparam int              CNT_W    = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

  mul_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              last_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              issue_s;

  assign issue_s = (state_q == MS_IDLE) && start_i;

  // last_q flags the completing cycle so busy/done need no counter compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MS_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      case (state_q)
        MS_IDLE: begin
          if (issue_s) begin
            state_q <= MS_MUL;
            cnt_q   <= CNT_LOAD;
            last_q  <= (CNT_LOAD == CNT_ONE);
            a_q     <= a_i;
            b_q     <= b_i;
          end else begin
            state_q <= MS_IDLE;
          end
        end
        MS_MUL: begin
          if (abort_i || (last_q && !hold_i)) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
          end else if (hold_i) begin
            state_q <= MS_MUL;
          end else begin
            cnt_q  <= cnt_q - CNT_ONE;
            last_q <= (cnt_q == CNT_TWO);
          end
        end
        default: begin
          state_q <= MS_IDLE;
          cnt_q   <= '0;
          last_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = issue_s || ((state_q == MS_MUL) && (!last_q || hold_i));
  assign done_o    = (state_q == MS_MUL) && last_q;
  assign product_o = a_q * b_q;

endmodule

// File: rtl/execute_stage_mc.sv
// Execute stage: operand forwarding, ALU, registered flags, branch resolution
// and the EX/MEM pipeline register. Multi-cycle multiplies run in exec_mul_unit.
module execute_stage_mc
  import exec_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int PC_W    = PC_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int MUL_LAT = MUL_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ValidE,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              JumpE,
  input  logic              ALUSrcE,
  input  logic              SetFlagsE,
  input  logic              Cant_ByteE,
  input  logic [1:0]        BranchE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1E,
  input  logic [DATA_W-1:0] RD2E,
  input  logic [DATA_W-1:0] ImmExtE,
  input  logic [PC_W-1:0]   PCE,
  input  logic [REG_AW-1:0] RDE,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic [DATA_W-1:0] ResultW,
  input  logic              FlushE,
  input  logic              HoldM,
  output logic              StallE,
  output logic              PCSrcE,
  output logic [PC_W-1:0]   PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic              Cant_ByteM,
  output logic              ValidM,
  output logic [REG_AW-1:0] RDM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ALUResultM
);

  localparam int   SH_W   = $clog2(DATA_W);
  localparam int   MSB    = DATA_W - 1;
  localparam logic MUL_MC = (MUL_LAT > 1);

  logic [DATA_W-1:0] src_a_s, src_b_fwd_s, src_b_s;
  logic [DATA_W-1:0] sum_s, diff_s, mul_direct_s, mul_product_s, alu_res_s;
  logic [SH_W-1:0]   shamt_s;
  logic              shift_big_s, alu_v_s;
  logic              mul_start_s, mul_busy_s, mul_done_s, flag_en_s;
  logic [2:0]        flags_d, flags_q;
  exmem_t            ctrl_d, ctrl_q;
  logic [REG_AW-1:0] rd_d, rd_q;
  logic [DATA_W-1:0] wd_d, wd_q, res_d, res_q;

  // Operand forwarding; the reserved select falls back to the register file.
  always_comb begin
    src_a_s = RD1E;
    case (fwd_sel_e'(ForwardA_E))
      FWD_W:   src_a_s = ResultW;
      FWD_M:   src_a_s = res_q;
      default: src_a_s = RD1E;
    endcase
    src_b_fwd_s = RD2E;
    case (fwd_sel_e'(ForwardB_E))
      FWD_W:   src_b_fwd_s = ResultW;
      FWD_M:   src_b_fwd_s = res_q;
      default: src_b_fwd_s = RD2E;
    endcase
  end

  assign src_b_s      = ALUSrcE ? ImmExtE : src_b_fwd_s;
  assign sum_s        = src_a_s + src_b_s;
  assign diff_s       = src_a_s - src_b_s;
  assign mul_direct_s = src_a_s * src_b_s;
  assign shamt_s      = src_b_s[SH_W-1:0];
  assign shift_big_s  = (32'(shamt_s) >= 32'(DATA_W));

  assign mul_start_s = ValidE && (alu_op_e'(ALUControlE) == ALU_MUL) && !FlushE && !HoldM && MUL_MC;

  exec_mul_unit #(
    .DATA_W  (DATA_W),
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk       (clk),
    .rst_n     (reset),
    .start_i   (mul_start_s),
    .abort_i   (FlushE),
    .hold_i    (HoldM),
    .a_i       (src_a_s),
    .b_i       (src_b_s),
    .busy_o    (mul_busy_s),
    .done_o    (mul_done_s),
    .product_o (mul_product_s)
  );

  assign StallE = mul_busy_s;

  // ALU result and signed overflow (overflow only meaningful for add/sub).
  always_comb begin
    alu_res_s = '0;
    alu_v_s   = 1'b0;
    case (alu_op_e'(ALUControlE))
      ALU_ADD: begin
        alu_res_s = sum_s;
        alu_v_s   = (src_a_s[MSB] == src_b_s[MSB]) && (sum_s[MSB] != src_a_s[MSB]);
      end
      ALU_SUB: begin
        alu_res_s = diff_s;
        alu_v_s   = (src_a_s[MSB] != src_b_s[MSB]) && (diff_s[MSB] != src_a_s[MSB]);
      end
      ALU_AND: alu_res_s = src_a_s & src_b_s;
      ALU_OR:  alu_res_s = src_a_s | src_b_s;
      ALU_XOR: alu_res_s = src_a_s ^ src_b_s;
      ALU_SHL: alu_res_s = shift_big_s ? '0 : (src_a_s << shamt_s);
      ALU_SHR: alu_res_s = shift_big_s ? '0 : (src_a_s >> shamt_s);
      ALU_MUL: alu_res_s = mul_done_s ? mul_product_s : mul_direct_s;
      default: alu_res_s = '0;
    endcase
  end

  assign flag_en_s = ValidE && SetFlagsE && !FlushE && !StallE && !HoldM;

  // Flag next-state: {Z, N, V}.
  always_comb begin
    if (flag_en_s) begin
      flags_d = {(alu_res_s == '0), alu_res_s[MSB], alu_v_s};
    end else begin
      flags_d = flags_q;
    end
  end

  // Flag register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign PCSrcE    = ValidE && !FlushE && !StallE &&
                     branch_cond(BranchE, flags_q[2], flags_q[1], flags_q[0], JumpE);
  assign PCTargetE = PCE + ImmExtE[PC_W-1:0];

  // EX/MEM next-state: hold beats bubble beats load.
  always_comb begin
    ctrl_d = ctrl_q;
    rd_d   = rd_q;
    wd_d   = wd_q;
    res_d  = res_q;
    if (HoldM) begin
      ctrl_d = ctrl_q;
    end else if (FlushE || StallE || !ValidE) begin
      ctrl_d = '0;
      rd_d   = '0;
      wd_d   = '0;
      res_d  = '0;
    end else begin
      ctrl_d = '{valid: 1'b1, reg_write: RegWriteE, mem_write: MemWriteE,
                 result_src: ResultSrcE, cant_byte: Cant_ByteE};
      rd_d   = RDE;
      wd_d   = src_b_fwd_s;
      res_d  = alu_res_s;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      rd_q   <= '0;
      wd_q   <= '0;
      res_q  <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      rd_q   <= rd_d;
      wd_q   <= wd_d;
      res_q  <= res_d;
    end
  end

  assign ValidM     = ctrl_q.valid;
  assign RegWriteM  = ctrl_q.reg_write;
  assign MemWriteM  = ctrl_q.mem_write;
  assign ResultSrcM = ctrl_q.result_src;
  assign Cant_ByteM = ctrl_q.cant_byte;
  assign RDM        = rd_q;
  assign WriteDataM = wd_q;
  assign ALUResultM = res_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Randomized scoreboard bench for execute_stage_mc against a behavioural model.
module tb_execute_stage_mc;

  localparam int DW = 19;
  localparam int PW = 15;
  localparam int AW = 5;
  localparam int ML = 3;
  localparam int SHMOD = 1 << $clog2(DW);
  localparam longint SMAX = (longint'(1) << (DW - 1)) - 1;
  localparam longint SMIN = -(longint'(1) << (DW - 1));

  logic clk, reset;
  logic ValidE, RegWriteE, MemWriteE, ResultSrcE, JumpE, ALUSrcE, SetFlagsE, Cant_ByteE;
  logic [1:0] BranchE, ForwardA_E, ForwardB_E;
  logic [2:0] ALUControlE;
  logic [DW-1:0] RD1E, RD2E, ImmExtE, ResultW;
  logic [PW-1:0] PCE;
  logic [AW-1:0] RDE;
  logic FlushE, HoldM;
  logic StallE, PCSrcE;
  logic [PW-1:0] PCTargetE;
  logic RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM, ValidM;
  logic [AW-1:0] RDM;
  logic [DW-1:0] WriteDataM, ALUResultM;

  execute_stage_mc #(.DATA_W(DW), .PC_W(PW), .REG_AW(AW), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .JumpE(JumpE), .ALUSrcE(ALUSrcE), .SetFlagsE(SetFlagsE),
    .Cant_ByteE(Cant_ByteE), .BranchE(BranchE), .ALUControlE(ALUControlE), .RD1E(RD1E),
    .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .RDE(RDE), .ForwardA_E(ForwardA_E),
    .ForwardB_E(ForwardB_E), .ResultW(ResultW), .FlushE(FlushE), .HoldM(HoldM),
    .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .Cant_ByteM(Cant_ByteM), .ValidM(ValidM),
    .RDM(RDM), .WriteDataM(WriteDataM), .ALUResultM(ALUResultM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic valid, rw, mw, rs, cb;
    logic [AW-1:0] rd;
    logic [DW-1:0] wd, res;
  } exp_t;

  exp_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic mz, mn, mv;
  int mwait;              // cycles left until the multiply completes (0 = none)
  logic [DW-1:0] mprod;
  logic [DW-1:0] m_alum;  // what EX/MEM currently holds as the ALU result
  logic m_stall;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] fwd(input logic [1:0] s, input logic [DW-1:0] rf);
    case (s)
      2'b01:   return ResultW;
      2'b10:   return m_alum;
      default: return rf;
    endcase
  endfunction

  function automatic void alu_ref(input logic [2:0] op, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, output logic [DW-1:0] r,
                                  output logic v);
    longint sa, sb, s;
    int amt;
    sa = a[DW-1] ? longint'(a) - (longint'(1) << DW) : longint'(a);
    sb = b[DW-1] ? longint'(b) - (longint'(1) << DW) : longint'(b);
    amt = int'(b) % SHMOD;
    v = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; v = (s > SMAX) || (s < SMIN); r = DW'(longint'(a) + longint'(b)); end
      3'd1: begin s = sa - sb; v = (s > SMAX) || (s < SMIN); r = DW'(longint'(a) - longint'(b)); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (amt >= DW) ? '0 : DW'(longint'(a) << amt);
      3'd6: r = (amt >= DW) ? '0 : DW'(longint'(a) >> amt);
      default: r = DW'(longint'(a) * longint'(b));
    endcase
  endfunction

  task automatic m_reset();
    mz = 1'b0; mn = 1'b0; mv = 1'b0;
    mwait = 0; mprod = '0; m_alum = '0; m_stall = 1'b0;
    sb_q.delete();
  endtask

  // One cycle: predict combinational outputs, check them, advance the model, push EX/MEM.
  task automatic step();
    logic [DW-1:0] a, bf, b, r;
    logic v, start, stall, cond, pcsrc;
    logic [PW-1:0] tgt;
    exp_t e;
    a  = fwd(ForwardA_E, RD1E);
    bf = fwd(ForwardB_E, RD2E);
    b  = ALUSrcE ? ImmExtE : bf;
    start = (mwait == 0) && ValidE && (ALUControlE == 3'd7) && !FlushE && !HoldM && (ML > 1);
    stall = start || (mwait > 1) || ((mwait == 1) && HoldM);
    alu_ref(ALUControlE, a, b, r, v);
    if (mwait == 1) r = mprod;
    cond = ((BranchE == 2'b11) && mz) || ((BranchE == 2'b01) && (mn == mv)) ||
           ((BranchE == 2'b10) && (mn != mv)) || JumpE;
    pcsrc = ValidE && !FlushE && !stall && cond;
    tgt = PW'(longint'(PCE) + longint'(ImmExtE));
    #1;
    chk("stall_pcsrc_target", 64'({StallE, PCSrcE, PCTargetE}), 64'({stall, pcsrc, tgt}));
    if (start) begin
      mwait = ML - 1;
      mprod = DW'(longint'(a) * longint'(b));
    end else if (mwait > 0) begin
      if (FlushE) mwait = 0;
      else if (!HoldM) mwait--;
    end
    if (ValidE && SetFlagsE && !FlushE && !stall && !HoldM) begin
      mz = (r == '0); mn = r[DW-1]; mv = v;
    end
    if (!HoldM) begin
      if (FlushE || stall || !ValidE) e = '{default: '0};
      else e = '{1'b1, RegWriteE, MemWriteE, ResultSrcE, Cant_ByteE, RDE, bf, r};
      sb_q.push_back(e);
      m_alum = e.res;
    end
    m_stall = stall;
    @(negedge clk);
  endtask

  task automatic clr();
    ValidE = 1'b1; RegWriteE = 1'b0; MemWriteE = 1'b0; ResultSrcE = 1'b0; JumpE = 1'b0;
    ALUSrcE = 1'b0; SetFlagsE = 1'b0; Cant_ByteE = 1'b0; BranchE = 2'b00; ALUControlE = 3'd0;
    RD1E = '0; RD2E = '0; ImmExtE = '0; PCE = '0; RDE = '0; ForwardA_E = 2'b00;
    ForwardB_E = 2'b00; FlushE = 1'b0; HoldM = 1'b0;
  endtask

  task automatic rnd_instr();
    ValidE = ($urandom_range(0, 9) != 0);
    RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ResultSrcE = 1'($urandom);
    Cant_ByteE = 1'($urandom); JumpE = ($urandom_range(0, 7) == 0);
    ALUSrcE = 1'($urandom); SetFlagsE = 1'($urandom);
    BranchE = 2'($urandom); ALUControlE = 3'($urandom);
    ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom);
    RD1E = DW'($urandom); RD2E = DW'($urandom); ImmExtE = DW'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      RD2E = DW'($urandom_range(0, 24)); ImmExtE = DW'($urandom_range(0, 40));
    end
    PCE = PW'($urandom); RDE = AW'($urandom);
  endtask

  // Monitor: each non-held edge pops one expected EX/MEM entry; held edges must not change it.
  initial begin : monitor
    exp_t last, e;
    logic h, r;
    last = '{default: '0};
    forever begin
      @(posedge clk);
      h = HoldM;
      r = reset;
      #1;
      if (!r) e = '{default: '0};
      else if (h) e = last;
      else if (sb_q.size() == 0) begin
        e = last;
        n_tests++; n_fail++;
        $display("FAIL sb_underflow: got no expected entry at %0t", $time);
      end else e = sb_q.pop_front();
      chk("exmem", 64'({ValidM, RegWriteM, MemWriteM, ResultSrcM, Cant_ByteM, RDM, WriteDataM, ALUResultM}),
          64'({e.valid, e.rw, e.mw, e.rs, e.cb, e.rd, e.wd, e.res}));
      last = e;
    end
  end

  initial begin : driver
    logic prev_flush;
    reset = 1'b0; clr(); ValidE = 1'b0; ResultW = '0;
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 64'({ValidM, RegWriteM, MemWriteM, StallE, ALUResultM}), 64'(0));
    @(negedge clk);
    reset = 1'b1;

    // ADD wrapping to 4.
    clr(); RD1E = 19'h00005; ImmExtE = 19'h7FFFF; ALUSrcE = 1'b1; SetFlagsE = 1'b1;
    RegWriteE = 1'b1; RDE = 5'd3; step();
    chk("add_result", 64'(ALUResultM), 64'(19'h00004));
    // SUB to zero then branch-equal.
    clr(); ALUControlE = 3'd1; RD1E = 19'd7; RD2E = 19'd7; SetFlagsE = 1'b1; step();
    clr(); BranchE = 2'b11; PCE = 15'h7FFE; ImmExtE = 19'd4; #1;
    chk("beq_taken", 64'({PCSrcE, PCTargetE}), 64'({1'b1, 15'h0002}));
    step();
    // Signed overflow then GE / LT.
    clr(); RD1E = 19'h3FFFF; RD2E = 19'h00001; SetFlagsE = 1'b1; step();
    clr(); BranchE = 2'b01; #1; chk("bge_after_ovf", 64'(PCSrcE), 64'(1)); step();
    clr(); BranchE = 2'b10; #1; chk("blt_after_ovf", 64'(PCSrcE), 64'(0)); step();
    // Multi-cycle MUL.
    clr(); ALUControlE = 3'd7; RD1E = 19'h00123; RD2E = 19'h00010; RegWriteE = 1'b1; RDE = 5'd9;
    repeat (3) step();
    chk("mul_result", 64'({ValidM, ALUResultM}), 64'({1'b1, 19'h01230}));
    // Forward from ALUResultM, then hold EX/MEM for two cycles.
    clr(); ForwardA_E = 2'b10; RD2E = 19'd1; SetFlagsE = 1'b1; step();
    clr(); ALUControlE = 3'd1; SetFlagsE = 1'b1; HoldM = 1'b1; step(); step();
    chk("hold_frozen", 64'(ALUResultM), 64'(19'h01231));
    clr(); BranchE = 2'b11; #1; chk("hold_flags_kept", 64'(PCSrcE), 64'(0)); step();
    // Flush on the second MUL cycle.
    clr(); ALUControlE = 3'd7; RD1E = 19'd3; RD2E = 19'd5; RegWriteE = 1'b1; step();
    FlushE = 1'b1; step();
    clr(); ValidE = 1'b0; #1;
    chk("flush_mul", 64'({StallE, ValidM}), 64'(0));
    step(); step();
    // Reset in the middle of a MUL.
    clr(); ALUControlE = 3'd1; RD1E = 19'd9; RD2E = 19'd9; SetFlagsE = 1'b1; step();
    clr(); ALUControlE = 3'd7; RD1E = 19'd6; RD2E = 19'd7; step();
    reset = 1'b0; ValidE = 1'b0; #1;
    chk("reset_mid_mul", 64'({StallE, ValidM, RegWriteM, MemWriteM, ALUResultM}), 64'(0));
    m_reset();
    @(negedge clk);
    reset = 1'b1;
    clr(); BranchE = 2'b11; #1; chk("flags_cleared", 64'(PCSrcE), 64'(0)); step();

    // Randomized traffic; ID/EX holds its instruction while StallE is high.
    prev_flush = 1'b0;
    clr(); rnd_instr();
    for (int i = 0; i < 1500; i++) begin
      if (!m_stall || prev_flush) rnd_instr();
      HoldM  = ($urandom_range(0, 5) == 0);
      FlushE = ($urandom_range(0, 11) == 0);
      ResultW = DW'($urandom);
      prev_flush = FlushE;
      step();
    end
    clr(); ValidE = 1'b0;
    repeat (4) step();
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
